// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_tx_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PRESCALE_W = 6;

    // Frame length in bit periods: start + 8 data + stop, optionally + parity.
    localparam int FRAME_BITS     = 10;
    localparam int FRAME_BITS_PAR = 11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/tx_baud_counter.sv
// Bit-period timer for uart_tx: counts prescale cycles per bit and tracks the data bit index.
module tx_baud_counter #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 3,
    parameter int LAST_BIT   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  bit_adv,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_done,
    output logic [BIT_W-1:0]      bit_idx,
    output logic                  bit_last
);

    logic [PRESCALE_W-1:0] cnt;
    logic [PRESCALE_W-1:0] cnt_last;

    // A prescale of zero behaves like one: every cycle ends a bit.
    assign cnt_last = (prescale == '0) ? '0 : prescale - 1'b1;
    assign bit_done = en && (cnt == cnt_last);
    assign bit_last = (bit_idx == BIT_W'(LAST_BIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || bit_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_idx <= '0;
        end else if (!en) begin
            bit_idx <= '0;
        end else if (bit_done && bit_adv) begin
            bit_idx <= bit_last ? '0 : bit_idx + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, one stop bit.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
`ifdef UART_TX_PARITY_EN
    input  logic                  par_en,
    input  logic                  par_typ,
`endif
    output logic                  tx_out,
    output logic                  busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e             state;
    tx_state_e             state_next;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [PRESCALE_W-1:0] pre_reg;
    logic                  accept;
    logic                  tx_next;
    logic                  bit_done;
    logic                  bit_last;
    logic [BIT_W-1:0]      bit_idx;
`ifdef UART_TX_PARITY_EN
    logic                  par_en_reg;
    logic                  par_bit_reg;
`endif

    assign accept = (state == IDLE) && data_valid;

    tx_baud_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_W      (BIT_W),
        .LAST_BIT   (DATA_WIDTH - 1)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .en       (state != IDLE),
        .bit_adv  (state == DATA),
        .prescale (pre_reg),
        .bit_done (bit_done),
        .bit_idx  (bit_idx),
        .bit_last (bit_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (data_valid) state_next = START;
            START: if (bit_done)   state_next = DATA;
            DATA: begin
                if (bit_done && bit_last) begin
`ifdef UART_TX_PARITY_EN
                    state_next = par_en_reg ? PARITY : STOP;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) state_next = STOP;
`endif
            STOP:  if (bit_done)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Line level for the current state; registered one cycle later into tx_out.
    always_comb begin
        tx_next = 1'b1;
        case (state)
            START:  tx_next = 1'b0;
            DATA:   tx_next = data_reg[bit_idx];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_next = par_bit_reg;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    // Frame parameters are frozen at accept so mid-frame input changes are harmless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg <= '0;
            pre_reg  <= '0;
        end else if (accept) begin
            data_reg <= data_in;
            pre_reg  <= prescale;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
        end else if (accept) begin
            par_en_reg  <= par_en;
            par_bit_reg <= (^data_in) ^ par_typ;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_out <= 1'b1;
            busy   <= 1'b0;
        end else begin
            tx_out <= tx_next;
            busy   <= (state != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: driver pushes expected frames, monitor decodes the line and compares.
module tb_uart_tx;

    localparam int PW = 6;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] prescale;
    logic [7:0]    data_in;
    logic          data_valid;
`ifdef UART_TX_PARITY_EN
    logic          par_en;
    logic          par_typ;
`endif
    logic          tx_out;
    logic          busy;

    uart_tx dut (
        .clk        (clk),
        .rst        (rst),
        .prescale   (prescale),
        .data_in    (data_in),
        .data_valid (data_valid),
`ifdef UART_TX_PARITY_EN
        .par_en     (par_en),
        .par_typ    (par_typ),
`endif
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         p;
        int         nb;
        logic       par_on;
        logic       par_bit;
        int         acc;
    } frame_t;

    frame_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Line level during bit period k of a frame.
    function automatic logic exp_bit(input frame_t e, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return e.data[k-1];
        if (e.par_on && k == 9) return e.par_bit;
        return 1'b1;
    endfunction

    // Issue one frame, then scramble inputs for the whole frame (they must be ignored).
    task automatic send(input logic [7:0] d, input int p, input bit pe, input bit pt,
                        input bit hold, input int mid_p, input int gap);
        frame_t e;
        data_in    = d;
        prescale   = PW'(p);
        data_valid = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_en  = pe;
        par_typ = pt;
`endif
        @(posedge clk); #1;
        e.data    = d;
        e.p       = (p == 0) ? 1 : p;
        e.par_on  = PAR_BUILT && pe;
        e.par_bit = (($countones(d) % 2) == 1) ^ pt;
        e.nb      = e.par_on ? 11 : 10;
        e.acc     = cyc;
        sb.push_back(e);
        repeat (e.p * e.nb) begin
            data_in  = 8'($urandom);
            prescale = (mid_p >= 0) ? PW'(mid_p) : PW'($urandom);
            if (!hold) data_valid = 1'($urandom);
`ifdef UART_TX_PARITY_EN
            par_en  = 1'($urandom);
            par_typ = 1'($urandom);
`endif
            @(posedge clk); #1;
        end
        if (gap > 0) begin
            data_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    // Monitor: detect start bits, pop the expected frame, compare every cycle.
    initial begin
        frame_t e;
        int     bad_cycles;
        bit     aborted;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx_out === 1'b0) begin
                if (sb.size() == 0) begin
                    check("spurious_start", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("start_latency", cyc, e.acc + 1);
                    bad_cycles = 0;
                    aborted    = 1'b0;
                    for (int i = 0; i < e.p * e.nb; i++) begin
                        if (i > 0) @(negedge clk);
                        if (rst !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tx_out !== exp_bit(e, i / e.p) || busy !== 1'b1) bad_cycles++;
                    end
                    if (!aborted) begin
                        check($sformatf("frame_wave_bad_cycles d=%02h p=%0d", e.data, e.p),
                              bad_cycles, 0);
                        @(negedge clk);
                        if (rst === 1'b1) check("post_frame_idle", {tx_out, busy}, 2'b10);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        frame_t     e;
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        prescale   = '0;
`ifdef UART_TX_PARITY_EN
        par_en  = 1'b0;
        par_typ = 1'b0;
`endif
        #1 rst = 1'b0;
        #2;
        check("reset_tx_out", tx_out, 1'b1);
        check("reset_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        send(8'hA5, 8, 1'b0, 1'b0, 1'b0, -1, 3);
`ifdef UART_TX_PARITY_EN
        send(8'hA5, 4, 1'b1, 1'b0, 1'b0, -1, 2);
        send(8'hA5, 4, 1'b1, 1'b1, 1'b0, -1, 2);
`endif
        send(8'h00, 16, 1'b0, 1'b0, 1'b1, -1, 0);
        send(8'hFF, 16, 1'b0, 1'b0, 1'b1, -1, 4);
        send(8'h3C, 8, 1'b0, 1'b0, 1'b0, 3, 5);
        send(8'h55, 0, 1'b0, 1'b0, 1'b0, -1, 2);
        send(8'h55, 1, 1'b0, 1'b0, 1'b0, -1, 2);

        // Reset in the middle of data bit 3 of a P=8 frame.
        d          = 8'hC6;
        data_in    = d;
        prescale   = PW'(8);
        data_valid = 1'b1;
        @(posedge clk); #1;
        e.data = d; e.p = 8; e.nb = 10; e.par_on = 1'b0; e.par_bit = 1'b0; e.acc = cyc;
        sb.push_back(e);
        data_valid = 1'b0;
        repeat (35) begin @(posedge clk); #1; end
        check("pre_reset_bit3", tx_out, d[3]);
        #2 rst = 1'b0;
        #1;
        check("async_reset_tx_out", tx_out, 1'b1);
        check("async_reset_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (60) begin @(posedge clk); #1; end
        check("after_reset_quiet", {tx_out, busy}, 2'b10);

        for (int n = 0; n < 40; n++) begin
            send(8'($urandom), int'($urandom_range(0, 12)), 1'($urandom), 1'($urandom),
                 1'($urandom), -1, int'($urandom_range(0, 3)));
        end

        data_valid = 1'b0;
        repeat (30) begin @(posedge clk); #1; end
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
